// File: rtl/pen_locator_pkg.sv
// Shared matrix geometry, locator state encoding and default probe timing.
// Timing defaults scale with CLOCK_FREQ so a clock change keeps the same settle/sample durations.
package pen_locator_pkg;

  localparam int CLOCK_FREQ = 50_000_000;

  localparam int MATRIX_N = 8;
  localparam int COORD_W  = 3;
  localparam int IDX_W    = 2 * COORD_W;

  // 100 us settle, 400 us sample window, hit at 75 % of the window
  localparam int DEF_SETTLE_CYCLES = CLOCK_FREQ / 10_000;
  localparam int DEF_SAMPLE_CYCLES = CLOCK_FREQ / 2_500;
  localparam int DEF_HIT_THRESHOLD = (DEF_SAMPLE_CYCLES * 3) / 4;

  typedef enum logic [1:0] {
    LOC_IDLE   = 2'd0,
    LOC_SETTLE = 2'd1,
    LOC_SAMPLE = 2'd2
  } loc_state_t;

  function automatic logic [MATRIX_N-1:0] onehot(input logic [COORD_W-1:0] v);
    logic [MATRIX_N-1:0] r;
    r    = '0;
    r[v] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/pen_locator_if.sv
// Probe/position bundle between the pen locator and led_driver, plus the locator's enable and pen inputs.
// master = locator side, slave = the system/led_driver side driving en/pen_i and consuming the rest.
interface pen_locator_if;
  import pen_locator_pkg::*;

  logic                en;
  logic                pen_i;
  logic                probe_active;
  logic [MATRIX_N-1:0] probe_row;
  logic [MATRIX_N-1:0] probe_col;
  logic [COORD_W-1:0]  pos_x;
  logic [COORD_W-1:0]  pos_y;
  logic                pos_valid;
  logic                sweep_miss;
  logic                tracking;

  modport master (
    input  en, pen_i,
    output probe_active, probe_row, probe_col, pos_x, pos_y, pos_valid, sweep_miss, tracking
  );

  modport slave (
    output en, pen_i,
    input  probe_active, probe_row, probe_col, pos_x, pos_y, pos_valid, sweep_miss, tracking
  );

endinterface

// File: rtl/pen_window_counter.sv
// Settle/sample down-counter and pen-high accumulator for one probe pixel; done/hit are combinational
// on the final window cycle so the verdict includes that cycle's pen sample. No backpressure.
module pen_window_counter #(
  parameter int SETTLE_CYCLES = 5000,
  parameter int SAMPLE_CYCLES = 20000,
  parameter int HIT_THRESHOLD = 15000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic load_settle,
  input  logic load_sample,
  input  logic sampling,
  input  logic pen_i,
  output logic settle_done,
  output logic window_done,
  output logic hit
);

  localparam int MAX_C = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int CNT_W = $clog2(MAX_C + 1);
  localparam int HIT_W = $clog2(SAMPLE_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic [HIT_W-1:0] hits;
  logic [HIT_W-1:0] hits_nxt;
  logic             cnt_zero;

  assign cnt_zero    = (cnt == '0);
  assign settle_done = !sampling && cnt_zero;
  assign window_done = sampling && cnt_zero;
  assign hits_nxt    = hits + HIT_W'(pen_i);
  assign hit         = (hits_nxt >= HIT_W'(HIT_THRESHOLD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      hits <= '0;
    end else if (clear) begin
      cnt  <= '0;
      hits <= '0;
    end else if (load_settle) begin
      cnt <= CNT_W'(SETTLE_CYCLES - 1);
    end else if (load_sample) begin
      cnt  <= CNT_W'(SAMPLE_CYCLES - 1);
      hits <= '0;
    end else begin
      if (!cnt_zero) cnt <= cnt - CNT_W'(1);
      if (sampling)  hits <= hits_nxt;
    end
  end

endmodule

// File: rtl/pen_locator.sv
// Raster-probes the 8x8 matrix one pixel at a time and reports where the pen sees light.
// Each pixel takes SETTLE_CYCLES+SAMPLE_CYCLES; results appear one cycle after the window ends. No backpressure.
module pen_locator
  import pen_locator_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
  parameter int HIT_THRESHOLD = DEF_HIT_THRESHOLD
) (
  input  logic          clk,
  input  logic          rst_n,
  pen_locator_if.master bus
);

  loc_state_t         state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [COORD_W-1:0] pos_x_nxt, pos_y_nxt;
  logic               pos_valid_nxt, sweep_miss_nxt, tracking_nxt;
  logic               clear, load_settle, load_sample;
  logic               settle_done, window_done, hit;

  pen_window_counter #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .SAMPLE_CYCLES(SAMPLE_CYCLES),
    .HIT_THRESHOLD(HIT_THRESHOLD)
  ) u_window (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .load_settle (load_settle),
    .load_sample (load_sample),
    .sampling    (state == LOC_SAMPLE),
    .pen_i       (bus.pen_i),
    .settle_done (settle_done),
    .window_done (window_done),
    .hit         (hit)
  );

  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    clear          = 1'b0;
    load_settle    = 1'b0;
    load_sample    = 1'b0;
    pos_x_nxt      = bus.pos_x;
    pos_y_nxt      = bus.pos_y;
    pos_valid_nxt  = 1'b0;
    sweep_miss_nxt = 1'b0;
    tracking_nxt   = bus.tracking;

    // Dropping en wins over a window that is ending this same cycle.
    if (!bus.en) begin
      state_nxt    = LOC_IDLE;
      idx_nxt      = '0;
      clear        = 1'b1;
      tracking_nxt = 1'b0;
    end else begin
      case (state)
        LOC_IDLE: begin
          state_nxt   = LOC_SETTLE;
          idx_nxt     = '0;
          load_settle = 1'b1;
        end
        LOC_SETTLE: begin
          if (settle_done) begin
            state_nxt   = LOC_SAMPLE;
            load_sample = 1'b1;
          end
        end
        LOC_SAMPLE: begin
          if (window_done) begin
            state_nxt   = LOC_SETTLE;
            load_settle = 1'b1;
            if (hit) begin
              pos_x_nxt     = idx[COORD_W-1:0];
              pos_y_nxt     = idx[IDX_W-1:COORD_W];
              pos_valid_nxt = 1'b1;
              tracking_nxt  = 1'b1;
              idx_nxt       = '0;
            end else if (idx == '1) begin
              idx_nxt        = '0;
              sweep_miss_nxt = 1'b1;
              tracking_nxt   = 1'b0;
            end else begin
              idx_nxt = idx + IDX_W'(1);
            end
          end
        end
        default: begin
          state_nxt = LOC_IDLE;
          idx_nxt   = '0;
          clear     = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= LOC_IDLE;
      idx              <= '0;
      bus.probe_active <= 1'b0;
      bus.probe_row    <= '0;
      bus.probe_col    <= '0;
      bus.pos_x        <= '0;
      bus.pos_y        <= '0;
      bus.pos_valid    <= 1'b0;
      bus.sweep_miss   <= 1'b0;
      bus.tracking     <= 1'b0;
    end else begin
      state            <= state_nxt;
      idx              <= idx_nxt;
      bus.probe_active <= (state_nxt != LOC_IDLE);
      bus.probe_row    <= (state_nxt != LOC_IDLE) ? onehot(idx_nxt[IDX_W-1:COORD_W]) : '0;
      bus.probe_col    <= (state_nxt != LOC_IDLE) ? onehot(idx_nxt[COORD_W-1:0]) : '0;
      bus.pos_x        <= pos_x_nxt;
      bus.pos_y        <= pos_y_nxt;
      bus.pos_valid    <= pos_valid_nxt;
      bus.sweep_miss   <= sweep_miss_nxt;
      bus.tracking     <= tracking_nxt;
    end
  end

endmodule

// File: tb/tb_pen_locator.sv
// Directed bench for pen_locator with 4/8/6 timing: 12 cycles per pixel, pixel k sampled on cycles 12k+5..12k+12.
// Cycle c counts rising edges after en is raised; results of pixel k appear at c = 12k+13.
module tb_pen_locator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pen_locator_if bus();

  pen_locator #(
    .SETTLE_CYCLES(4),
    .SAMPLE_CYCLES(8),
    .HIT_THRESHOLD(6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int c = 0;
  int pv_cnt, pv_first, sm_cnt, sm_first;
  int trk_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_stats();
    pv_cnt = 0; pv_first = -1; sm_cnt = 0; sm_first = -1; trk_seen = 0;
  endtask

  // Pen sees light when the lit probe is the target pixel, or unconditionally on cycles lo..hi.
  task automatic run(input int n, input int target, input int lo, input int hi, input int en_off);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      c++;
      if (bus.pos_valid === 1'b1) begin
        pv_cnt++;
        if (pv_first < 0) pv_first = c;
      end
      if (bus.sweep_miss === 1'b1) begin
        sm_cnt++;
        if (sm_first < 0) sm_first = c;
      end
      if (bus.tracking === 1'b1) trk_seen = 1;
      if (c == en_off) bus.en = 1'b0;
      bus.pen_i = (bus.probe_active && target >= 0 &&
                   bus.probe_row == 8'(1 << (target / 8)) &&
                   bus.probe_col == 8'(1 << (target % 8))) || (c >= lo && c <= hi);
    end
  endtask

  task automatic restart();
    bus.en    = 1'b0;
    bus.pen_i = 1'b0;
    @(posedge clk);
    #1;
    chk("restart_idle_active", 32'(bus.probe_active), 0);
    bus.en = 1'b1;
    c = 0;
    clr_stats();
  endtask

  initial begin
    logic [31:0] idle_or;
    bus.en    = 1'b0;
    bus.pen_i = 1'b0;
    clr_stats();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_probe_active", 32'(bus.probe_active), 0);
    chk("rst_probe_row",    32'(bus.probe_row), 0);
    chk("rst_probe_col",    32'(bus.probe_col), 0);
    chk("rst_pos_x",        32'(bus.pos_x), 0);
    chk("rst_pos_y",        32'(bus.pos_y), 0);
    chk("rst_pos_valid",    32'(bus.pos_valid), 0);
    chk("rst_sweep_miss",   32'(bus.sweep_miss), 0);
    chk("rst_tracking",     32'(bus.tracking), 0);

    rst_n   = 1'b1;
    idle_or = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      idle_or = idle_or | 32'({bus.probe_active, bus.probe_row, bus.probe_col, bus.pos_x,
                               bus.pos_y, bus.pos_valid, bus.sweep_miss, bus.tracking});
    end
    chk("idle_outputs_zero", idle_or, 0);

    // Single hit at row 3, col 5 (idx 29)
    restart();
    run(1, 29, -1, -1, -1);
    chk("first_probe_active", 32'(bus.probe_active), 1);
    chk("first_probe_row",    32'(bus.probe_row), 32'h01);
    run(349, 29, -1, -1, -1);
    chk("px29_probe_row", 32'(bus.probe_row), 32'h08);
    chk("px29_probe_col", 32'(bus.probe_col), 32'h20);
    run(11, 29, -1, -1, -1);
    chk("hit_pv_count",  pv_cnt, 1);
    chk("hit_pv_cycle",  pv_first, 361);
    chk("hit_pos_x",     32'(bus.pos_x), 5);
    chk("hit_pos_y",     32'(bus.pos_y), 3);
    chk("hit_tracking",  32'(bus.tracking), 1);
    chk("hit_next_row",  32'(bus.probe_row), 32'h01);
    chk("hit_next_col",  32'(bus.probe_col), 32'h01);
    chk("hit_no_miss",   sm_cnt, 0);

    // Threshold edge at idx 10: 6 of 8 sample cycles, including the last
    restart();
    run(133, -1, 127, 132, -1);
    chk("thr6_pv_count", pv_cnt, 1);
    chk("thr6_pv_cycle", pv_first, 133);
    chk("thr6_pos_x",    32'(bus.pos_x), 2);
    chk("thr6_pos_y",    32'(bus.pos_y), 1);

    // One short of threshold: no hit, sweep moves on to idx 11
    restart();
    chk("thr5_tracking_cleared", 32'(bus.tracking), 0);
    run(133, -1, 128, 132, -1);
    chk("thr5_pv_count", pv_cnt, 0);
    chk("thr5_next_row", 32'(bus.probe_row), 32'h02);
    chk("thr5_next_col", 32'(bus.probe_col), 32'h08);

    // Full sweep with pen dark
    restart();
    run(769, -1, -1, -1, -1);
    chk("miss_sm_count",   sm_cnt, 1);
    chk("miss_sm_cycle",   sm_first, 769);
    chk("miss_pv_count",   pv_cnt, 0);
    chk("miss_trk_seen",   trk_seen, 0);
    chk("miss_wrap_row",   32'(bus.probe_row), 32'h01);
    chk("miss_wrap_col",   32'(bus.probe_col), 32'h01);
    chk("miss_pos_x_held", 32'(bus.pos_x), 2);

    // Abort: en drops on the final sample cycle of a would-be hit at (7,7)
    restart();
    run(769, 63, -1, -1, 768);
    chk("abort_pv_count",     pv_cnt, 0);
    chk("abort_sm_count",     sm_cnt, 0);
    chk("abort_probe_active", 32'(bus.probe_active), 0);
    chk("abort_pos_x_held",   32'(bus.pos_x), 2);
    chk("abort_pos_y_held",   32'(bus.pos_y), 1);
    chk("abort_tracking",     32'(bus.tracking), 0);

    // Asynchronous reset during settle of idx 40
    restart();
    run(482, -1, -1, -1, -1);
    chk("pre_arst_row", 32'(bus.probe_row), 32'h20);
    rst_n = 1'b0;
    #1;
    chk("arst_probe_active", 32'(bus.probe_active), 0);
    chk("arst_probe_row",    32'(bus.probe_row), 0);
    chk("arst_probe_col",    32'(bus.probe_col), 0);
    chk("arst_pos_x",        32'(bus.pos_x), 0);
    chk("arst_pos_y",        32'(bus.pos_y), 0);
    #1;
    rst_n = 1'b1;
    c = 0;
    run(1, -1, -1, -1, -1);
    chk("post_arst_active", 32'(bus.probe_active), 1);
    chk("post_arst_row",    32'(bus.probe_row), 32'h01);
    chk("post_arst_col",    32'(bus.probe_col), 32'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
